sensor_monitor: RTL and testbench
=================================

SENSOR_MONITOR -- requirements
Module: sensor_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of the incoming summed-frequency word and of avg/baseline.
REQ-002 SHALL have parameter AVG_LOG2, default 4, log2 of samples per averaging window.
REQ-003 SHALL have parameter DELTA, default 16, deviation above which the alarm is entered.
REQ-004 SHALL have parameter HYST, default 4, hysteresis below DELTA required to leave the alarm; HYST < DELTA.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  monitor enable.
REQ-008 SHALL have port sum_valid  input  1  sum qualifier; one sample per high cycle.
REQ-009 SHALL have port sum  input  WIDTH  unsigned summed sensor frequency from the adder stage.
REQ-010 SHALL have port calib_start  input  1  single-cycle request to (re)learn the baseline.
REQ-011 SHALL have port avg  output  WIDTH  last completed window average.
REQ-012 SHALL have port avg_valid  output  1  one-cycle pulse when avg updates.
REQ-013 SHALL have port baseline  output  WIDTH  learned reference average.
REQ-014 SHALL have port alarm  output  1  high while in ALARM.
REQ-015 SHALL have port state  output  2  FSM state: IDLE=0, CALIB=1, MONITOR=2, ALARM=3.

Function
REQ-016 SHALL accumulate sum into a WIDTH+AVG_LOG2-bit accumulator with a AVG_LOG2-bit sample counter, only when sum_valid=1 and state is not IDLE; no overflow possible.
REQ-017 SHALL complete a window on the cycle accepting sample 2^AVG_LOG2; in the next cycle: avg=(acc+sum)>>AVG_LOG2 (truncating), avg_valid=1 for one cycle, acc and counter cleared, and state/baseline/alarm updated per REQ-019..021.
REQ-018 SHALL stay in IDLE until calib_start=1 with en=1, then enter CALIB with acc and counter cleared.
REQ-019 CALIB: on window completion SHALL load baseline with the new avg and go to MONITOR.
REQ-020 MONITOR: on window completion SHALL compute dev=|avg-baseline| (unsigned, WIDTH+1 bits) and go to ALARM if dev > DELTA.
REQ-021 ALARM: on window completion SHALL return to MONITOR if dev < DELTA-HYST, otherwise remain.
REQ-022 calib_start in MONITOR or ALARM SHALL go to CALIB next cycle, clear alarm, acc and counter; a sum_valid in that same cycle SHALL be discarded.
REQ-023 en=0 in any state SHALL go to IDLE next cycle, clear alarm, acc and counter, retain baseline and avg; en=0 takes priority over calib_start and sum_valid.
REQ-024 alarm SHALL be registered and equal (state==ALARM); no combinational path from inputs to any output.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, avg=0, avg_valid=0, baseline=0, alarm=0, acc=0, counter=0.
REQ-026 Reset deassertion mid-window SHALL leave no partial accumulation; first window after reset starts from zero.

Configuration
REQ-027 Macro SENSOR_MONITOR_STICKY_ALARM_EN defined: ALARM SHALL be left only via calib_start or en=0; REQ-021 hysteresis exit disabled.
REQ-028 Macro undefined: ALARM exit SHALL follow REQ-021.

Verification (AVG_LOG2=2, DELTA=16, HYST=4, WIDTH=16)
REQ-029 en=1, calib_start, sum=100 x4 -> avg_valid pulse, avg=100, baseline=100, state=MONITOR.
REQ-030 Then sum=120 x4 -> avg=120, alarm=1, state=ALARM in avg_valid cycle; then sum=113 x4 -> alarm stays 1; then sum=111 x4 -> alarm=0, state=MONITOR (with STICKY macro: alarm stays 1).
REQ-031 Window sum=101,102,102,102 -> avg=101 (truncation); sum=0xFFFF x4 -> avg=0xFFFF, no wrap.
REQ-032 en dropped after 2 of 4 samples in ALARM -> state=IDLE, alarm=0, baseline kept; re-enable plus calib_start with sum=50 x4 -> baseline=50, no stale samples included.
REQ-033 calib_start coincident with sum_valid (sum=900) in MONITOR -> sample discarded, next 4 samples of 200 give baseline=200.
REQ-034 rst_n asserted asynchronously mid-window -> all outputs 0 immediately without a clock edge; after release, no avg_valid until 4 new samples after calib.

Source files
------------

// File: rtl/sensor_monitor.sv
// Windowed averaging sensor monitor with baseline calibration and hysteresis alarm.
// Optional macro SENSOR_MONITOR_STICKY_ALARM_EN: alarm is left only via calib_start or en=0.
module sensor_monitor #(
  parameter int WIDTH    = 16,
  parameter int AVG_LOG2 = 4,
  parameter int DELTA    = 16,
  parameter int HYST     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sum_valid,
  input  logic [WIDTH-1:0] sum,
  input  logic             calib_start,
  output logic [WIDTH-1:0] avg,
  output logic             avg_valid,
  output logic [WIDTH-1:0] baseline,
  output logic             alarm,
  output logic [1:0]       state
);

  localparam int AW = WIDTH + AVG_LOG2;
  localparam logic [WIDTH:0] DELTA_W = (WIDTH+1)'(DELTA);
  localparam logic [WIDTH:0] EXIT_W  = (WIDTH+1)'(DELTA - HYST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALIB   = 2'd1,
    MONITOR = 2'd2,
    ALARM   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       acc;
  logic [AVG_LOG2-1:0] cnt;

  logic                restart;
  logic                accept;
  logic                win_done;
  logic                clr;
  logic [AW-1:0]       total;
  logic [WIDTH-1:0]    new_avg;
  logic [WIDTH:0]      dev;

  // A recalibration request wins over a sample arriving in the same cycle.
  assign restart  = en && calib_start && (state_q != CALIB);
  assign accept   = en && sum_valid && (state_q != IDLE) && !restart;
  assign win_done = accept && (cnt == '1);
  assign clr      = !en || restart || win_done;

  assign total   = acc + AW'(sum);
  assign new_avg = total[AW-1:AVG_LOG2];
  assign dev     = (new_avg >= baseline) ? ({1'b0, new_avg} - {1'b0, baseline})
                                         : ({1'b0, baseline} - {1'b0, new_avg});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else if (restart) begin
      state_d = CALIB;
    end else begin
      case (state_q)
        CALIB:   if (win_done) state_d = MONITOR;
        MONITOR: if (win_done && (dev > DELTA_W)) state_d = ALARM;
        ALARM: begin
`ifdef SENSOR_MONITOR_STICKY_ALARM_EN
          state_d = ALARM;
`else
          if (win_done && (dev < EXIT_W)) state_d = MONITOR;
`endif
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output logic
  always_comb begin
    state = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      baseline  <= '0;
      alarm     <= 1'b0;
    end else begin
      avg_valid <= win_done;
      alarm     <= (state_d == ALARM);
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        acc <= total;
        cnt <= cnt + 1'b1;
      end
      if (win_done) begin
        avg <= new_avg;
        if (state_q == CALIB) baseline <= new_avg;
      end
    end
  end

endmodule

// File: tb/tb_sensor_monitor.sv
// Directed bench for sensor_monitor: stimulus pushes expected window results,
// an avg_valid-driven monitor pops and compares them.
module tb_sensor_monitor;

  localparam int W  = 16;
  localparam int EW = 2 + 1 + W + W;  // {state, alarm, baseline, avg}

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         sum_valid = 1'b0;
  logic [W-1:0] sum = '0;
  logic         calib_start = 1'b0;
  logic [W-1:0] avg;
  logic         avg_valid;
  logic [W-1:0] baseline;
  logic         alarm;
  logic [1:0]   state;

  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  sensor_monitor #(.WIDTH(16), .AVG_LOG2(2), .DELTA(16), .HYST(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sum_valid(sum_valid), .sum(sum),
    .calib_start(calib_start), .avg(avg), .avg_valid(avg_valid),
    .baseline(baseline), .alarm(alarm), .state(state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && avg_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_avg_valid: got avg=0x%0h with no expectation queued", avg);
      end else begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        e = exp_q.pop_front();
        a = {state, alarm, baseline, avg};
        if (a !== e) begin
          fails++;
          $display("FAIL window: got st=%0d alarm=%0b base=%0d avg=%0d expected st=%0d alarm=%0b base=%0d avg=%0d",
                   a[34:33], a[32], a[31:16], a[15:0], e[34:33], e[32], e[31:16], e[15:0]);
        end
      end
    end
  end

  // Driver tasks: inputs change on the falling edge
  task automatic drive(input logic v, input logic [W-1:0] s, input logic cs);
    @(negedge clk);
    sum_valid   = v;
    sum         = s;
    calib_start = cs;
  endtask

  task automatic expect_win(input logic [1:0] st, input logic al, input logic [W-1:0] b,
                            input logic [W-1:0] a);
    exp_q.push_back({st, al, b, a});
  endtask

  task automatic window(input logic [W-1:0] s0, s1, s2, s3, input logic [1:0] st,
                        input logic al, input logic [W-1:0] b, input logic [W-1:0] a);
    drive(1'b1, s0, 1'b0);
    drive(1'b1, s1, 1'b0);
    drive(1'b1, s2, 1'b0);
    drive(1'b1, s3, 1'b0);
    expect_win(st, al, b, a);
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic calib();
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("calib_state", 32'(state), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_avg", 32'(avg), 32'd0);
    chk("rst_baseline", 32'(baseline), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_avg_valid", 32'(avg_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0);
    en = 1'b1;
    drive(1'b1, 16'd5, 1'b0);
    chk("idle_holds", 32'(state), 32'd0);

    calib();
    window(100, 100, 100, 100, 2'd2, 1'b0, 100, 100);
    window(120, 120, 120, 120, 2'd3, 1'b1, 100, 120);
    window(113, 113, 113, 113, 2'd3, 1'b1, 100, 113);
`ifdef SENSOR_MONITOR_STICKY_ALARM_EN
    window(111, 111, 111, 111, 2'd3, 1'b1, 100, 111);
    window(101, 102, 102, 102, 2'd3, 1'b1, 100, 101);
`else
    window(111, 111, 111, 111, 2'd2, 1'b0, 100, 111);
    window(101, 102, 102, 102, 2'd2, 1'b0, 100, 101);
`endif
    window(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'd3, 1'b1, 100, 16'hFFFF);

    // en drop mid-window in ALARM, coincident with calib_start
    drive(1'b1, 16'd7, 1'b0);
    drive(1'b1, 16'd7, 1'b0);
    @(negedge clk);
    en = 1'b0; calib_start = 1'b1; sum_valid = 1'b1; sum = 16'd9;
    drive(1'b0, '0, 1'b0);
    chk("en_off_state", 32'(state), 32'd0);
    chk("en_off_alarm", 32'(alarm), 32'd0);
    chk("en_off_baseline", 32'(baseline), 32'd100);
    chk("en_off_avg", 32'(avg), 32'hFFFF);
    en = 1'b1;
    calib();
    window(50, 50, 50, 50, 2'd2, 1'b0, 50, 50);

    // calib_start with a coincident sample in MONITOR: sample dropped
    drive(1'b1, 16'd900, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("recal_state", 32'(state), 32'd1);
    chk("recal_alarm", 32'(alarm), 32'd0);
    window(200, 200, 200, 200, 2'd2, 1'b0, 200, 200);

    // Asynchronous reset mid-window
    drive(1'b1, 16'd300, 1'b0);
    drive(1'b1, 16'd300, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_avg", 32'(avg), 32'd0);
    chk("arst_baseline", 32'(baseline), 32'd0);
    chk("arst_alarm", 32'(alarm), 32'd0);
    chk("arst_avg_valid", 32'(avg_valid), 32'd0);
    drive(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 16'd7, 1'b0);
    drive(1'b1, 16'd7, 1'b0);
    calib();
    drive(1'b1, 16'd40, 1'b0);
    drive(1'b1, 16'd40, 1'b0);
    drive(1'b1, 16'd40, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("partial_state", 32'(state), 32'd1);
    drive(1'b1, 16'd40, 1'b0);
    expect_win(2'd2, 1'b0, 40, 40);
    drive(1'b0, '0, 1'b0);

    // Drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
